// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-client SRAM arbiter.
// Build option: SRAM_ARB_INIT_EN selects the post-reset zero-fill sweep.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

    typedef enum logic {
        INIT,
        RUN
    } sram_arb_state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [MASK_W_DEF-1:0] wmask;
        logic [DATA_W_DEF-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_if.sv
// Client request/response bundle: master is the cache-side client, slave is the arbiter.
interface sram_arb_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MASK_W = DATA_W / 8
);
    logic              valid;
    logic              ready;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output valid, write, addr, wmask, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, write, addr, wmask, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin grant: one-hot grant from valids, owns last_grant.
module sram_arb_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last_grant_q, last_grant_d;

    // grant is only raised when en is high, so grant doubles as the fire signal
    always_comb begin
        grant = '0;
        if (en) begin
            if (valid == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/sram_rw_arbiter.sv
// Two-client arbiter/sequencer for a 1-cycle-read single-port byte-masked SRAM.
// Build option: SRAM_ARB_INIT_EN enables the post-reset zero-fill sweep.
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    sram_arb_if.slave         req0,
    sram_arb_if.slave         req1,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);
`ifdef SRAM_ARB_INIT_EN
    localparam sram_arb_state_e RESET_STATE = INIT;
    localparam logic [ADDR_W:0] LAST_PTR    = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] PTR_ONE     = {{ADDR_W{1'b0}}, 1'b1};
`else
    localparam sram_arb_state_e RESET_STATE = RUN;
`endif

    sram_arb_state_e   state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;
    logic              run_en;
    logic [1:0]        grant;
    logic              mux_write;
    logic [ADDR_W-1:0] mux_addr;
    logic [MASK_W-1:0] mux_wmask;
    logic [DATA_W-1:0] mux_wdata;
`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_W:0]   init_ptr_q, init_ptr_d;
`endif

    // Outputs are gated by reset so the reset-time values hold while reset is high
    assign run_en = !reset && (state_q == RUN);

    sram_arb_rr2 u_rr2 (
        .clock (clock),
        .reset (reset),
        .en    (run_en),
        .valid ({req1.valid, req0.valid}),
        .grant (grant)
    );

    always_comb begin
        mux_write = grant[1] ? req1.write : req0.write;
        mux_addr  = grant[1] ? req1.addr  : req0.addr;
        mux_wmask = grant[1] ? req1.wmask : req0.wmask;
        mux_wdata = grant[1] ? req1.wdata : req0.wdata;
    end

    always_comb begin
        state_d    = state_q;
        sram_en    = |grant;
        sram_wmode = mux_write;
        sram_addr  = mux_addr;
        sram_wmask = mux_wmask;
        sram_wdata = mux_wdata;
`ifdef SRAM_ARB_INIT_EN
        init_ptr_d = init_ptr_q;
        if (state_q == INIT) begin
            sram_en    = !reset;
            sram_wmode = 1'b1;
            sram_addr  = init_ptr_q[ADDR_W-1:0];
            sram_wmask = '1;
            sram_wdata = '0;
            init_ptr_d = init_ptr_q + PTR_ONE;
            if (init_ptr_q == LAST_PTR) begin
                state_d = RUN;
            end
        end
`endif
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        if ((|grant) && !mux_write) begin
            rd_pend_d = 1'b1;
            rd_port_d = grant[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
`ifdef SRAM_ARB_INIT_EN
            init_ptr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
`ifdef SRAM_ARB_INIT_EN
            init_ptr_q <= init_ptr_d;
`endif
        end
    end

    assign req0.ready     = grant[0];
    assign req1.ready     = grant[1];
    assign req0.rsp_valid = !reset && rd_pend_q && !rd_port_q;
    assign req1.rsp_valid = !reset && rd_pend_q && rd_port_q;
    assign req0.rsp_rdata = sram_rdata;
    assign req1.rsp_rdata = sram_rdata;

`ifdef SRAM_ARB_INIT_EN
    assign init_done = !reset && (state_q == RUN);
`else
    assign init_done = 1'b1;
`endif
endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester arbiter and sequencer for one single-port, byte-masked, read/write behavioural SRAM macro with 1024 × 32 bits and 1-cycle registered read. It sits between two cache-side clients and the macro's `RW0_*` port. It grants one request per cycle with round-robin fairness and returns read data one cycle after the grant. It can optionally sweep the array to zero after reset.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width; `DEPTH = 1 << ADDR_W`.
- `DATA_W`, 32, SRAM word width.
- `MASK_W`, `DATA_W/8`, byte-lane mask width.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock for the arbiter and the SRAM.
- `reset`  in  1  synchronous, active-high.
- `reqN_valid`  in  1  request from client N (N = 0, 1).
- `reqN_ready`  out  1  arbiter accepts client N's request this cycle.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  word address.
- `reqN_wmask`  in  MASK_W  byte enables; used on writes only.
- `reqN_wdata`  in  DATA_W  write data.
- `rspN_valid`  out  1  read data for client N is valid this cycle. There is no backpressure on responses.
- `rspN_rdata`  out  DATA_W  read data, driven from `sram_rdata` to both clients.
- `sram_en`, `sram_wmode`  out  1  connect to `RW0_en` and `RW0_wmode`.
- `sram_addr`  out  ADDR_W  connects to `RW0_addr`.
- `sram_wmask`  out  MASK_W  connects to `RW0_wmask`.
- `sram_wdata`  out  DATA_W  connects to `RW0_wdata`.
- `sram_rdata`  in  DATA_W  connects to `RW0_rdata`.
- `init_done`  out  1  arbiter is accepting requests.

## Operation
State machine with states `INIT` and `RUN`.

**Arbitration in `RUN`**
- Only one request is granted per cycle. Grant is combinational from the valids and a `last_grant` register.
- Only one client valid: that client is granted.
- Both clients valid: grant the client that is not `last_grant`.
- `last_grant` updates on every fire (`valid && ready`).
- `last_grant` resets to 1, so client 0 wins the first contention.
- `reqN_ready` = `state==RUN && grantN`. A valid request is never starved for more than 1 cycle.

**Granted request**
- SRAM drive: `sram_en=1`, `sram_wmode=write`, and addr/wmask/wdata are muxed combinationally from the granted client.
- No grant: `sram_en=0`; the other SRAM outputs hold the client-0 mux values (don't-care).
- Read fire: register `rd_pend=1` and `rd_port=N`. Next cycle, assert `rspN_valid`, with `rspN_rdata = sram_rdata`.
- Write fire produces no response.
- A write of a word is visible to a read granted in any later cycle.

**Reset mid-operation**
- An outstanding read is dropped: `rd_pend` is cleared, so no `rsp*_valid` in the cycle after reset.
- The state returns to `INIT` (macro on) or `RUN` (macro off).
- SRAM contents are not otherwise touched.

Reset values:
- `reqN_ready=0`, `rspN_valid=0`, `sram_en=0`.
- `init_done`: 0 with the macro on, 1 with it off (see Configuration).
- `last_grant=1`, `rd_pend=0`, `init_ptr=0`.

## Timing
- Request → SRAM: 0 cycles (combinational pass-through on fire).
- Read fire in cycle t → `rspN_valid` in cycle t+1. Throughput is 1 request per cycle; back-to-back reads pipeline.
- INIT sweep (macro on):
  - Reset asserted in cycle 0; cycle 1 is the first cycle with reset low.
  - Cycles 1..DEPTH write zeros to addresses 0..DEPTH-1, full mask.
  - `init_done=1` and the earliest `reqN_ready` from cycle DEPTH+1.
- `init_ptr` is ADDR_W+1 bits. The sweep ends when it reaches DEPTH, with no wrap to 0.
- Reset asserted during the sweep restarts it at address 0.

## Configuration
Macro `SRAM_ARB_INIT_EN`:
- **Defined:** after reset the FSM enters `INIT` and zero-fills the array as above. Requests are held off with `ready=0` throughout.
- **Undefined:** the `INIT` state, `init_ptr` and the zero-write mux are compiled out. The FSM resets into `RUN`, `init_done=1` during and after reset, and requests are accepted from the first cycle with reset low.

## Structure
- Package `sram_arb_pkg` holds:
  - the state typedef `sram_arb_state_e` (`INIT`, `RUN`);
  - default `ADDR_W`/`DATA_W` constants;
  - the request struct `sram_req_t` (write, addr, wmask, wdata).
- One sub-module, `sram_arb_rr2`: the 2-way round-robin grant logic. It takes the valids and an enable, returns one-hot grants, and owns `last_grant`.
- The SRAM macro is instantiated by the parent, not inside this block.

## Test plan
- **Init sweep (macro on):** after reset, `init_done` rises exactly at cycle 1025. All 1024 addresses read back 0x00000000, and no `ready` is asserted before then.
- **Contention fairness:** both clients continuously request reads for 8 cycles. Grants alternate 0,1,0,1,…, and each `rspN_valid` arrives 1 cycle after that client's fire.
- **Byte mask:** client 0 writes 0xAABBCCDD with mask 0xF to addr 5, then 0x11223344 with mask 0b0101. Client 1 then reads addr 5 and gets 0xAA22CC44 the cycle after its fire.
- **Read-after-write back-to-back:** write 0xDEADBEEF to addr 0x3FF in cycle t and read addr 0x3FF in cycle t+1. The response in t+2 is 0xDEADBEEF.
- **Reset mid-read:** fire a read, then assert reset the next cycle. No `rsp*_valid` is observed. With the macro on, the sweep restarts at addr 0 and completes in 1024 cycles.
- **Macro off:** `init_done=1` throughout, and a read fired in the first post-reset cycle returns a response in the next cycle.
